tdm_demux_1_to_4: RTL
=====================

Name: tdm_demux_1_to_4

Overview:
- Receive end of the 4-lane time-division link. Upstream, a 4:1 mux driven by a slot counter serializes lanes a/b/c/d.
- This block takes that serialized stream and tracks the slot position, with a start-of-frame marker for sync.
- It rebuilds each 4-slot frame into parallel lane registers and presents the frame downstream with a valid/ready handshake.
- It flags framing and overrun errors.

Parameters:
- WIDTH, 1, bit width of each lane and of data_in.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  serialized lane data, one slot per accepted beat.
- in_valid  input  1  data_in/frame_start qualify this cycle.
- frame_start  input  1  marks the current beat as slot 0 (lane a); meaningful only with in_valid.
- s0  output  1  current expected slot, MSB.
- s1  output  1  current expected slot, LSB. Slot {s0,s1}: 00=a, 01=b, 10=c, 11=d.
- out_a  output  WIDTH  frame lane a (slot 00).
- out_b  output  WIDTH  frame lane b (slot 01).
- out_c  output  WIDTH  frame lane c (slot 10).
- out_d  output  WIDTH  frame lane d (slot 11).
- out_valid  output  1  out_a..out_d hold a complete frame.
- out_ready  input  1  downstream accepts the frame when out_valid && out_ready.
- sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame.
- overrun  output  1  one-cycle pulse: completed frame dropped because the output was still occupied.

Behaviour:
- Reset (async, rst=1): state=IDLE, {s0,s1}=00, staging registers=0, out_a..out_d=0, out_valid=0, sync_err=0, overrun=0. Reset asserted mid-frame discards the partial frame and any pending output frame.
- States:
  - IDLE: waiting for frame_start.
  - COLLECT: slots 01..11 expected.
- Beats with in_valid=0 change nothing; slot position holds.
- IDLE:
  - in_valid && frame_start: data_in -> stage_a, {s0,s1}<=01, go to COLLECT.
  - in_valid && !frame_start: beat ignored silently, no error.
- COLLECT:
  - in_valid && frame_start: sync_err=1 next cycle. Partial frame discarded. The current beat is taken as a new slot 0 (data_in -> stage_a, {s0,s1}<=01). Stay in COLLECT.
  - in_valid && !frame_start, slot 01: data_in -> stage_b, slot<=10.
  - in_valid && !frame_start, slot 10: data_in -> stage_c, slot<=11.
  - in_valid && !frame_start, slot 11: frame complete. {s0,s1}<=00, go to IDLE (every frame needs its own frame_start).
- Frame completion:
  - If out_valid=0, or out_valid && out_ready this same cycle: out_a<=stage_a, out_b<=stage_b, out_c<=stage_c, out_d<=data_in, out_valid<=1.
  - Otherwise: frame dropped; outputs keep the old frame; overrun=1 next cycle.
- Latency: out_valid rises the cycle after the slot-11 beat is accepted.
- Handshake:
  - out_valid && out_ready with no simultaneous completion: out_valid<=0. Lane outputs hold their value until the next load.
  - Simultaneous accept and completion: out_valid stays 1 with the new frame; no overrun.
  - Lane outputs are stable while out_valid=1 && out_ready=0.
- sync_err and overrun are single-cycle pulses, registered, and mutually independent. A sync_err pulse never produces a frame.
- No arithmetic beyond the 2-bit slot increment; slot never wraps 11->00 except on completion or reset.

Test Plan:
- WIDTH=8, out_ready=1. Beats (fs=1,0x11),(0x22),(0x33),(0x44) -> one cycle after 4th beat: out_a/b/c/d=11/22/33/44, out_valid=1; next cycle out_valid=0; {s0,s1} steps 00,01,10,11,00.
- in_valid gaps: same frame with in_valid=0 for 2 cycles between each beat -> identical output; {s0,s1} holds during gaps.
- Resync: fs beat 0xAA, 0xBB, then fs beat 0x01, 0x02, 0x03, 0x04 -> sync_err pulses once; output frame is 01/02/03/04 only.
- Backpressure:
  - out_ready=0; send frame A (1,2,3,4) then frame B (5,6,7,8) -> overrun pulses once after B's 4th beat; outputs stay 1/2/3/4 with out_valid=1.
  - Set out_ready=1 -> out_valid drops.
- Simultaneous: out_valid=1 with frame A; out_ready=1 exactly in the cycle B's slot-11 beat arrives -> no overrun; out_valid stays 1; outputs become B.
- Reset mid-frame: assert rst after slot 10 with out_valid=1 -> all outputs 0 immediately (async); after release, beats without frame_start are ignored and no error pulses.

Source files
------------

// File: rtl/tdm_demux_1_to_4.sv
// Receive side of the 4-lane TDM link: tracks slot position from frame_start,
// rebuilds each 4-slot frame and hands it downstream with valid/ready.
module tdm_demux_1_to_4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   input  logic             frame_start,
   output logic             s0,
   output logic             s1,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sync_err,
   output logic             overrun
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t           state, state_nxt;
   logic [1:0]       slot, slot_nxt;
   logic [WIDTH-1:0] stage_a, stage_b, stage_c;
   logic [WIDTH-1:0] stage_a_nxt, stage_b_nxt, stage_c_nxt;
   logic [WIDTH-1:0] out_a_nxt, out_b_nxt, out_c_nxt, out_d_nxt;
   logic             out_valid_nxt, sync_err_nxt, overrun_nxt;

   assign s0 = slot[1];
   assign s1 = slot[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         slot      <= 2'b00;
         stage_a   <= '0;
         stage_b   <= '0;
         stage_c   <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_c     <= '0;
         out_d     <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         slot      <= slot_nxt;
         stage_a   <= stage_a_nxt;
         stage_b   <= stage_b_nxt;
         stage_c   <= stage_c_nxt;
         out_a     <= out_a_nxt;
         out_b     <= out_b_nxt;
         out_c     <= out_c_nxt;
         out_d     <= out_d_nxt;
         out_valid <= out_valid_nxt;
         sync_err  <= sync_err_nxt;
         overrun   <= overrun_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      slot_nxt      = slot;
      stage_a_nxt   = stage_a;
      stage_b_nxt   = stage_b;
      stage_c_nxt   = stage_c;
      out_a_nxt     = out_a;
      out_b_nxt     = out_b;
      out_c_nxt     = out_c;
      out_d_nxt     = out_d;
      out_valid_nxt = out_valid;
      sync_err_nxt  = 1'b0;
      overrun_nxt   = 1'b0;

      if (out_valid && out_ready)
         out_valid_nxt = 1'b0;

      if (in_valid) begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  stage_a_nxt = data_in;
                  slot_nxt    = 2'b01;
                  state_nxt   = COLLECT;
               end
            end
            COLLECT: begin
               if (frame_start) begin
                  // Restart on the new marker; the partial frame is simply overwritten.
                  sync_err_nxt = 1'b1;
                  stage_a_nxt  = data_in;
                  slot_nxt     = 2'b01;
               end else begin
                  case (slot)
                     2'b01: begin
                        stage_b_nxt = data_in;
                        slot_nxt    = 2'b10;
                     end
                     2'b10: begin
                        stage_c_nxt = data_in;
                        slot_nxt    = 2'b11;
                     end
                     2'b11: begin
                        slot_nxt  = 2'b00;
                        state_nxt = IDLE;
                        // Output slot is free if empty or being drained this cycle.
                        if (!out_valid || out_ready) begin
                           out_a_nxt     = stage_a;
                           out_b_nxt     = stage_b;
                           out_c_nxt     = stage_c;
                           out_d_nxt     = data_in;
                           out_valid_nxt = 1'b1;
                        end else begin
                           overrun_nxt = 1'b1;
                        end
                     end
                     default: begin
                        slot_nxt = slot;
                     end
                  endcase
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
